// File: rtl/adex_pkg.sv
// Shared types and defaults for the AdEx AER receiver.
// Imported by the receiver top and its event FIFO.
package adex_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } aer_state_t;

  localparam int ADDR_W_DEF = 6;
  localparam int W_W_DEF    = 8;
  localparam int EVT_CNT_W  = 16;

endpackage

// File: rtl/adex_aer_fifo.sv
// Synchronous event FIFO between the AER handshake and the integrator.
// Push is refused when full, pop is ignored when empty.
module adex_aer_fifo
  import adex_pkg::*;
#(
  parameter int W     = ADDR_W_DEF,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // next storage, pointers and occupancy
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  // state registers; storage cleared so the head reads 0 after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adex_aer_rx.sv
// Off-chip AER spike receiver: req synchroniser, 4-phase handshake,
// event FIFO and per-synapse weight lookup for the AdEx integrator.
module adex_aer_rx
  import adex_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int W_W         = W_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int WEIGHT_INIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 aer_req,
  input  logic [ADDR_W-1:0]    aer_addr,
  output logic                 aer_ack,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_sel,
  input  logic [W_W-1:0]       cfg_wdata,
  output logic                 syn_valid,
  input  logic                 syn_ready,
  output logic [ADDR_W-1:0]    syn_addr,
  output logic [W_W-1:0]       syn_weight,
  output logic                 fifo_full,
  output logic [EVT_CNT_W-1:0] evt_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  aer_state_t             state_q, state_d;
  logic                   ack_q, ack_d;
  logic [W_W-1:0]         wgt_q [4];
  logic [W_W-1:0]         wgt_d [4];
  logic [EVT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   req_s;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic                   can_push;
  logic [CW-1:0]          fifo_cnt;

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign can_push  = (fifo_cnt < CW'(FIFO_DEPTH));
  assign syn_valid = ~empty;
  assign pop       = syn_valid & syn_ready;
  assign aer_ack   = ack_q;
  assign evt_count = cnt_q;
  assign syn_weight = wgt_q[syn_addr[1:0]];

  adex_aer_fifo #(
    .W     (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (aer_addr),
    .dout  (syn_addr),
    .full  (fifo_full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // synchroniser shift: aer_req enters at bit 0
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], aer_req};
  end

  // handshake FSM: capture in IDLE, hold ack until req drops
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_s && ena && can_push) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ack_d = (state_d == ACK);
  end

  // weight writes and saturating event counter
  always_comb begin
    wgt_d = wgt_q;
    cnt_d = cnt_q;
    if (cfg_we) begin
      wgt_d[cfg_sel] = cfg_wdata;
    end
    if (push && (cnt_q != '1)) begin
      cnt_d = cnt_q + EVT_CNT_W'(1);
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        wgt_q[i] <= W_W'(WEIGHT_INIT);
      end
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      wgt_q   <= wgt_d;
    end
  end

endmodule

// File: tb/tb_adex_aer_rx.sv
// Directed plus randomized bench for adex_aer_rx.
// Expected events come from a queue model of the FIFO.
module tb_adex_aer_rx;

  localparam int AW = 6;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          aer_req;
  logic [AW-1:0] aer_addr;
  logic          aer_ack;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [WW-1:0] cfg_wdata;
  logic          syn_valid;
  logic          syn_ready;
  logic [AW-1:0] syn_addr;
  logic [WW-1:0] syn_weight;
  logic          fifo_full;
  logic [15:0]   evt_count;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] q[$];
  logic [WW-1:0] wm[4];
  int            cnt_m;

  adex_aer_rx dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .aer_req    (aer_req),
    .aer_addr   (aer_addr),
    .aer_ack    (aer_ack),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_wdata  (cfg_wdata),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .syn_addr   (syn_addr),
    .syn_weight (syn_weight),
    .fifo_full  (fifo_full),
    .evt_count  (evt_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cnt_m = 0;
    for (int i = 0; i < 4; i++) wm[i] = 8'd16;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    model_reset();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ack(logic lvl, output int n);
    n = 0;
    while (aer_ack !== lvl && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic send(logic [AW-1:0] a);
    int n;
    aer_addr = a;
    aer_req  = 1'b1;
    wait_ack(1'b1, n);
    chk("ack_rise", aer_ack, 1);
    if (aer_ack === 1'b1) begin
      q.push_back(a);
      cnt_m++;
    end
    aer_req = 1'b0;
    wait_ack(1'b0, n);
    chk("ack_fall", aer_ack, 0);
  endtask

  task automatic pop_one();
    logic [AW-1:0] h;
    h = q[0];
    chk("head_valid", syn_valid, 1);
    chk("head_addr", syn_addr, h);
    chk("head_weight", syn_weight, wm[h[1:0]]);
    syn_ready = 1'b1;
    tick();
    syn_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic drain();
    while (q.size() > 0) pop_one();
    chk("drain_empty", syn_valid, 0);
    chk("evt_count", evt_count, cnt_m);
  endtask

  task automatic cfg(logic [1:0] s, logic [WW-1:0] v);
    cfg_we    = 1'b1;
    cfg_sel   = s;
    cfg_wdata = v;
    tick();
    cfg_we = 1'b0;
    wm[s]  = v;
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    rst       = 1'b1;
    ena       = 1'b1;
    aer_req   = 1'b0;
    aer_addr  = '0;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_wdata = '0;
    syn_ready = 1'b0;
    model_reset();
    tick();
    chk("rst_ack", aer_ack, 0);
    chk("rst_valid", syn_valid, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_cnt", evt_count, 0);
    chk("rst_addr", syn_addr, 0);
    chk("rst_weight", syn_weight, 8'd16);
    do_reset();

    // 1: single event, latency both ways
    aer_addr = 6'h2D;
    aer_req  = 1'b1;
    wait_ack(1'b1, n);
    chk("rise_lat", n, 3);
    chk("t1_valid", syn_valid, 1);
    chk("t1_addr", syn_addr, 6'h2D);
    chk("t1_weight", syn_weight, 8'd16);
    q.push_back(6'h2D);
    cnt_m++;
    aer_req = 1'b0;
    wait_ack(1'b0, n);
    chk("fall_lat", n, 3);
    chk("t1_cnt", evt_count, 1);
    drain();

    // 2: back-pressure with 5 events
    for (int i = 0; i < 4; i++) send(AW'($urandom));
    chk("t2_full", fifo_full, 1);
    a = AW'($urandom);
    aer_addr = a;
    aer_req  = 1'b1;
    repeat (10) tick();
    chk("t2_withheld", aer_ack, 0);
    chk("t2_still_full", fifo_full, 1);
    pop_one();
    wait_ack(1'b1, n);
    chk("t2_ack5", aer_ack, 1);
    q.push_back(a);
    cnt_m++;
    aer_req = 1'b0;
    wait_ack(1'b0, n);
    chk("t2_fall5", aer_ack, 0);
    drain();

    // 3: weight slots, applied at pop time
    cfg(2'd1, 8'hF8);
    send(6'h05);
    chk("t3_neg", syn_weight, 8'hF8);
    pop_one();
    send(6'h04);
    chk("t3_init", syn_weight, 8'd16);
    pop_one();
    send(6'h09);
    cfg(2'd1, 8'h33);
    chk("t3_late", syn_weight, 8'h33);
    drain();

    // 4: reset during handshake
    aer_addr = 6'h1A;
    aer_req  = 1'b1;
    wait_ack(1'b1, n);
    chk("t4_ack", aer_ack, 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_ack_drop", aer_ack, 0);
    chk("t4_empty", syn_valid, 0);
    chk("t4_cnt", evt_count, 0);
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    wait_ack(1'b1, n);
    chk("t4_reaccept", n, 3);
    q.push_back(6'h1A);
    cnt_m++;
    chk("t4_cnt1", evt_count, 1);
    aer_req = 1'b0;
    wait_ack(1'b0, n);
    drain();

    // 5: ena gating
    ena      = 1'b0;
    aer_addr = 6'h3C;
    aer_req  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_no_ack", aer_ack, 0);
    end
    chk("t5_no_push", syn_valid, 0);
    ena = 1'b1;
    tick();
    chk("t5_ack_1edge", aer_ack, 1);
    q.push_back(6'h3C);
    cnt_m++;
    aer_req = 1'b0;
    wait_ack(1'b0, n);
    aer_addr = 6'h11;
    aer_req  = 1'b1;
    wait_ack(1'b1, n);
    q.push_back(6'h11);
    cnt_m++;
    ena     = 1'b0;
    aer_req = 1'b0;
    wait_ack(1'b0, n);
    chk("t5_ack_done", aer_ack, 0);
    ena = 1'b1;
    drain();

    // 6: push and pop on the same edge
    send(AW'($urandom));
    send(AW'($urandom));
    a = AW'($urandom);
    aer_addr = a;
    aer_req  = 1'b1;
    tick();
    tick();
    chk("t6_pre_ack", aer_ack, 0);
    chk("t6_head0", syn_addr, q[0]);
    syn_ready = 1'b1;
    tick();
    syn_ready = 1'b0;
    chk("t6_ack", aer_ack, 1);
    void'(q.pop_front());
    q.push_back(a);
    cnt_m++;
    chk("t6_head1", syn_addr, q[0]);
    chk("t6_not_full", fifo_full, 0);
    aer_req = 1'b0;
    wait_ack(1'b0, n);
    drain();

    // randomized mix of events, pops and weight writes
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: if (q.size() < 4) send(AW'($urandom));
        1: if (q.size() > 0) pop_one();
        2: cfg(2'($urandom), WW'($urandom));
        default: begin
          if (q.size() > 0) begin
            a = q[0];
            cfg(a[1:0], WW'($urandom));
            pop_one();
          end
        end
      endcase
      chk("rnd_full", fifo_full, (q.size() == 4));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
